// File: rtl/aes_hdr.sv
// ============================================================================
// Package      : aes_pkg
// Description  : Shared types, the AES-128 round count and GF(2^8) xtime.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  typedef logic [3:0][3:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_fsm_t;

  localparam int AES128_NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_comb.sv
// ============================================================================
// Module       : aes_round_comb
// Description  : One combinational AES round (SubBytes, ShiftRows, optional
//                MixColumns, AddRoundKey). Byte k = 4*col + row sits at [15-k].
// Revision     : 1.0
// ============================================================================
`default_nettype none

module aes_round_comb
  import aes_pkg::*;
(
  input  aes_state_t        state_i,
  input  logic [127:0]      rkey_i,
  input  logic [255:0][7:0] sbox_i,
  input  logic              last_round_i,
  output aes_state_t        state_o
);

  logic [15:0][7:0] b_in;
  logic [15:0][7:0] b_sr;
  logic [15:0][7:0] b_mc;

  always_comb begin
    b_in = state_i;
    b_sr = '0;
    b_mc = '0;
    // Row r of output column c takes the byte from column (c + r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        b_sr[15-(4*c+r)] = sbox_i[b_in[15-(4*((c+r)%4)+r)]];
      end
    end
    for (int c = 0; c < 4; c++) begin
      b_mc[15-4*c] = xtime(b_sr[15-4*c]) ^ xtime(b_sr[14-4*c]) ^ b_sr[14-4*c]
                   ^ b_sr[13-4*c] ^ b_sr[12-4*c];
      b_mc[14-4*c] = b_sr[15-4*c] ^ xtime(b_sr[14-4*c]) ^ xtime(b_sr[13-4*c])
                   ^ b_sr[13-4*c] ^ b_sr[12-4*c];
      b_mc[13-4*c] = b_sr[15-4*c] ^ b_sr[14-4*c] ^ xtime(b_sr[13-4*c])
                   ^ xtime(b_sr[12-4*c]) ^ b_sr[12-4*c];
      b_mc[12-4*c] = xtime(b_sr[15-4*c]) ^ b_sr[15-4*c] ^ b_sr[14-4*c]
                   ^ b_sr[13-4*c] ^ xtime(b_sr[12-4*c]);
    end
    state_o = (last_round_i ? b_sr : b_mc) ^ rkey_i;
  end

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_iter.sv
// ============================================================================
// Module       : aes_encrypt_iter
// Description  : Iterative AES-128 encryptor, one round per eph1 cycle.
//                Optional debug ports enabled by macro AES_ENC_DBG_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                   eph1,
  input  logic                   reset,
  input  logic [255:0][7:0]      SBOX,
  input  logic [10:0][3:0][31:0] key_words,
  input  logic                   keys_ready,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_data,
  output logic                   abort
`ifdef AES_ENC_DBG_EN
  ,
  output logic [3:0]             dbg_rnd,
  output logic [127:0]           dbg_state
`endif
);

  generate
    if (NR != AES128_NR) begin : g_nr_check
      $error("aes_encrypt_iter supports only NR = 10");
    end
  endgenerate

  aes_fsm_t     fsm_q;
  logic [3:0]   rnd_q;
  aes_state_t   state_q;
  aes_state_t   round_d;
  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic         abort_q;
  logic [127:0] rkey;
  logic         last_round;

  assign rkey       = key_words[rnd_q];
  assign last_round = (rnd_q == 4'(NR));

  aes_round_comb u_round (
    .state_i      (state_q),
    .rkey_i       (rkey),
    .sbox_i       (SBOX),
    .last_round_i (last_round),
    .state_o      (round_d)
  );

  always_ff @(posedge eph1) begin
    if (reset) begin
      fsm_q       <= IDLE;
      rnd_q       <= 4'd0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      abort_q     <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (in_valid && keys_ready) begin
            state_q <= in_data ^ key_words[0];
            rnd_q   <= 4'd1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          // Losing the keys mid-block drops the block; DONE ignores keys_ready.
          if (!keys_ready) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            abort_q <= 1'b1;
          end else begin
            state_q <= round_d;
            if (last_round) begin
              fsm_q       <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= round_d;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            rnd_q       <= 4'd0;
            out_valid_q <= 1'b0;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm_q == IDLE) && keys_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign abort     = abort_q;

`ifdef AES_ENC_DBG_EN
  assign dbg_rnd   = rnd_q;
  assign dbg_state = state_q;
`endif

endmodule

`default_nettype wire

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative AES-128 encryption core that sits directly downstream of keyschedule.
- Consumes the 11 expanded round keys and the ready flag from keyschedule, and accepts one 128-bit plaintext block per handshake.
- Executes initial AddRoundKey plus 10 rounds, one round per eph1 cycle, and presents the ciphertext on a valid/ready output handshake.

Parameters:
- NR, 10, number of AES rounds; only 10 (AES-128) is supported, and elaboration fails for any other value.

Ports:
- eph1  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- SBOX  input  [255:0][7:0]  forward S-box, same table and index order as keyschedule.
- key_words  input  [10:0][3:0][31:0]  round keys; key_words[i] is round key i, word [3] = most-significant word.
- keys_ready  input  1  driven by keyschedule ready; key_words are valid while high.
- in_valid  input  1  plaintext offered.
- in_ready  output  1  core can accept plaintext.
- in_data  input  128  plaintext; bit 127..120 = state byte s[0,0], column-major per FIPS-197.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  128  ciphertext, same byte order as in_data.
- abort  output  1  one-cycle pulse when an operation is dropped because keys_ready fell.

Behaviour:
- FSM states and transitions:
  - IDLE: in_ready = keys_ready. On in_valid & in_ready: state <= in_data ^ key_words[0], rnd <= 1, go to RUN.
  - RUN: state <= round(state, key_words[rnd]), rnd <= rnd+1. The round with rnd==10 omits MixColumns; after it, go to DONE.
  - DONE: out_valid=1, out_data=state, held stable until out_ready. On out_valid & out_ready, go to IDLE.
- Latency: out_valid rises on the 10th posedge after the accept edge. Throughput is one block per 12 cycles minimum; with out_ready tied high there is one IDLE bubble between blocks.
- in_ready is 0 in RUN and DONE; there is no overlap between blocks.
- Round function: SubBytes via SBOX[byte], ShiftRows (row r rotated left by r), MixColumns in GF(2^8) with xtime reduction 8'h1b, then AddRoundKey.
- rnd is a 4-bit counter covering 1..10; it never wraps, because RUN exits at 10.
- keys_ready low while in RUN:
  - go to IDLE and pulse abort for 1 cycle;
  - state contents are don't-care; out_valid never asserts for that block.
- keys_ready low while in DONE: ignored; the ciphertext is already final.
- Reset applies in any state, including mid-RUN and mid-DONE. Values after reset:
  - FSM = IDLE, rnd = 0, state = 0;
  - out_valid = 0, out_data = 0, abort = 0;
  - in_ready = keys_ready.
- Simultaneous in_valid with reset: reset wins; the block is not accepted.
- in_data is sampled only on the accept edge; later changes are ignored.

Optional Feature:
- Macro AES_ENC_DBG_EN.
- Defined: adds output dbg_rnd [3:0] (current rnd) and output dbg_state [127:0] (live state register), both reset to 0.
- Undefined: neither port nor its logic exists, and functional behaviour is identical.

Decomposition:
- Package aes_pkg in aes_hdr.sv holds:
  - typedef aes_state_t = logic [3:0][3:0][7:0];
  - typedef aes_fsm_t enum {IDLE, RUN, DONE};
  - localparam AES128_NR = 10;
  - function xtime.
- One combinational sub-module, aes_round_comb:
  - inputs: state, round key, SBOX, last_round;
  - output: next state.
- The top module holds the FSM, counter, registers and handshakes, using rregs for flops.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, with out_valid 10 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout; release -> IDLE next cycle, in_ready=1.
- keys_ready=0 with in_valid=1 -> in_ready=0, no accept. Drop keys_ready at round 4 -> one abort pulse, IDLE, no out_valid.
- Assert reset at round 6 -> next cycle FSM=IDLE, out_valid=0, out_data=0; a subsequent App. C.1 run still gives the correct result.
- Back-to-back with out_ready=1: two blocks -> second accept exactly 1 cycle after the first output handshake; both ciphertexts correct.
